// File: rtl/countdown_display_mux.sv
// countdown_display_mux
//   Converts the 6-bit countdown value to two BCD digits with a sequential
//   shift-add-3 (double-dabble) engine and scans them onto one shared
//   active-low 7-segment bus. A one-entry pending buffer captures updates
//   that arrive while a conversion is running (latest wins).
//
//   Optional build macro: DISPLAY_LEADING_ZERO_BLANK_EN
//     defined   -> a tens digit of 0 is blanked while the tens digit is enabled
//     undefined -> a tens digit of 0 is shown as "0"
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low
//   value        binary count (0-63)
//   value_valid  single-cycle strobe, value is new
//   busy         conversion in progress (SHIFT or COMMIT)
//   bcd_tens     displayed tens digit
//   bcd_units    displayed units digit
//   an           digit enables, active low: an[0] units, an[1] tens
//   seg          segments, active low, seg[0]=a .. seg[6]=g

module countdown_display_mux #(
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned CNT_W       = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] value,
  input  logic             value_valid,
  output logic             busy,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_units,
  output logic [1:0]       an,
  output logic [6:0]       seg
);

  localparam int unsigned ShW  = CNT_W + 8;
  localparam int unsigned UnLo = CNT_W;
  localparam int unsigned TnLo = CNT_W + 4;
  localparam int unsigned ScnW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

  state_e           state_q, state_d;
  logic [ShW-1:0]   shift_q, shift_d, shift_nxt;
  logic [2:0]       iter_q, iter_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pend_val_q, pend_val_d;
  logic [3:0]       tens_q, tens_d, units_q, units_d;
  logic             busy_q, busy_d;
  logic [ScnW-1:0]  scan_q, scan_d;
  logic [1:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             start;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // One double-dabble iteration: correct nibbles >= 5, then shift left.
  always_comb begin
    logic [ShW-1:0] adj;
    adj = shift_q;
    if (adj[UnLo +: 4] >= 4'd5) adj[UnLo +: 4] = adj[UnLo +: 4] + 4'd3;
    if (adj[TnLo +: 4] >= 4'd5) adj[TnLo +: 4] = adj[TnLo +: 4] + 4'd3;
    shift_nxt = adj << 1;
  end

  // Conversion FSM and pending buffer
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    iter_d     = iter_q;
    pend_d     = pend_q;
    pend_val_d = pend_val_q;
    tens_d     = tens_q;
    units_d    = units_q;
    start      = 1'b0;

    unique case (state_q)
      StIdle: begin
        start = value_valid | pend_q;
      end
      StShift: begin
        shift_d = shift_nxt;
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'(CNT_W - 1)) state_d = StCommit;
      end
      StCommit: begin
        tens_d  = shift_q[TnLo +: 4];
        units_d = shift_q[UnLo +: 4];
        state_d = StIdle;
        // A waiting value chains straight into the next conversion.
        start   = pend_q;
      end
      default: state_d = StIdle;
    endcase

    if (start) begin
      state_d = StShift;
      iter_d  = 3'd0;
      shift_d = {8'b0, (pend_q ? pend_val_q : value)};
      // Pending is consumed first; a simultaneous strobe takes its place.
      pend_d  = pend_q & value_valid;
      if (value_valid) pend_val_d = value;
    end else if (value_valid && (state_q != StIdle)) begin
      pend_d     = 1'b1;
      pend_val_d = value;
    end

    busy_d = (state_d != StIdle);
  end

  // Digit scan; seg is decoded from next-state values so it lands with an.
  always_comb begin
    logic [3:0] digit;
    if (scan_q == ScnW'(REFRESH_DIV - 1)) begin
      scan_d = '0;
      an_d   = ~an_q;
    end else begin
      scan_d = scan_q + ScnW'(1);
      an_d   = an_q;
    end
    digit = an_d[1] ? units_d : tens_d;
    seg_d = seg_decode(digit);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    if (!an_d[1] && (tens_d == 4'd0)) seg_d = 7'b1111111;
`else
    // Leading zero shown as "0".
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      iter_q     <= '0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      tens_q     <= '0;
      units_q    <= '0;
      busy_q     <= 1'b0;
      scan_q     <= '0;
      an_q       <= 2'b10;
      seg_q      <= 7'b1000000;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      iter_q     <= iter_d;
      pend_q     <= pend_d;
      pend_val_q <= pend_val_d;
      tens_q     <= tens_d;
      units_q    <= units_d;
      busy_q     <= busy_d;
      scan_q     <= scan_d;
      an_q       <= an_d;
      seg_q      <= seg_d;
    end
  end

  assign busy      = busy_q;
  assign bcd_tens  = tens_q;
  assign bcd_units = units_q;
  assign an        = an_q;
  assign seg       = seg_q;

endmodule
